cathetus: RTL and testbench



---
 rtl/sr_arith_pkg.sv | 21 ++
 rtl/isqrt_step.sv | 29 ++
 rtl/cathetus.sv | 137 +++++++++++++
 tb/tb_cathetus.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_arith_pkg.sv
// Shared widths, FSM encoding and constants for the sequential arithmetic units.
// Latency: none; this package holds declarations only.
// Backpressure: none; the handshake is defined by the units that use it.
package sr_arith_pkg;

  localparam int C_W        = 9;
  localparam int A_W        = 8;
  localparam int SQ_W       = 18;
  localparam int ROOT_ITERS = 9;

  // Highest even power of two that fits SQ_W; one root bit resolved per iteration.
  localparam logic [SQ_W-1:0] M_INIT = SQ_W'(1) << (2 * (ROOT_ITERS - 1));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    DIFF   = 2'd2,
    ROOT   = 2'd3
  } state_t;

endpackage

// File: rtl/isqrt_step.sv
// One digit-by-digit integer square root iteration (one result bit per call).
// Latency: purely combinational.
// Backpressure: none; the caller sequences iterations.
module isqrt_step
  import sr_arith_pkg::*;
(
  input  logic [SQ_W-1:0] x,
  input  logic [SQ_W-1:0] res,
  input  logic [SQ_W-1:0] m,
  output logic [SQ_W-1:0] x_next,
  output logic [SQ_W-1:0] res_next,
  output logic [SQ_W-1:0] m_next
);

  logic [SQ_W-1:0] t;

  // Trial-subtract the candidate bit; keep it only if the remainder stays non-negative.
  always_comb begin
    t        = res | m;
    x_next   = x;
    res_next = res >> 1;
    if (x >= t) begin
      x_next   = x - t;
      res_next = (res >> 1) | m;
    end
    m_next = m >> 2;
  end

endmodule

// File: rtl/cathetus.sv
// Computes b = floor(sqrt(c^2 - a^2)); flags err when a > c.
// Latency: 19 cycles busy on the normal path, 10 cycles on the error path.
// Backpressure: start_i is sampled only while idle; requests during busy are dropped.
module cathetus
  import sr_arith_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [C_W-1:0] c_bi,
  input  logic [A_W-1:0] a_bi,
  output logic [C_W-1:0] b_bo,
  output logic           err_o,
  output logic           busy_o
);

  state_t          state, state_nxt;
  logic [C_W-1:0]  c_q, c_nxt;
  logic [A_W-1:0]  a_q, a_nxt;
  logic [3:0]      ctr, ctr_nxt;
  logic [SQ_W-1:0] sq_c, sq_c_nxt;
  logic [15:0]     sq_a, sq_a_nxt;
  logic [SQ_W-1:0] x, x_nxt;
  logic [SQ_W-1:0] res, res_nxt;
  logic [SQ_W-1:0] m, m_nxt;
  logic [C_W-1:0]  b_nxt;
  logic            err_nxt;

  logic [SQ_W-1:0] pp_c;
  logic [15:0]     pp_a;
  logic            a_bit;
  logic [SQ_W-1:0] step_x, step_res, step_m;

  isqrt_step u_step (
    .x        (x),
    .res      (res),
    .m        (m),
    .x_next   (step_x),
    .res_next (step_res),
    .m_next   (step_m)
  );

  // Shift-and-add partial products for the current multiplier bit; a has one bit fewer than c.
  always_comb begin
    a_bit = a_q[ctr[2:0]] & ~ctr[3];
    pp_c  = {9'd0, c_q & {C_W{c_q[ctr]}}} << ctr;
    pp_a  = {8'd0, a_q & {A_W{a_bit}}} << ctr[2:0];
  end

  // Next-state and datapath update; everything holds unless the current state says otherwise.
  always_comb begin
    state_nxt = state;
    c_nxt     = c_q;
    a_nxt     = a_q;
    ctr_nxt   = ctr;
    sq_c_nxt  = sq_c;
    sq_a_nxt  = sq_a;
    x_nxt     = x;
    res_nxt   = res;
    m_nxt     = m;
    b_nxt     = b_bo;
    err_nxt   = err_o;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          c_nxt     = c_bi;
          a_nxt     = a_bi;
          ctr_nxt   = '0;
          sq_c_nxt  = '0;
          sq_a_nxt  = '0;
          state_nxt = SQUARE;
        end
      end
      SQUARE: begin
        sq_c_nxt = sq_c + pp_c;
        sq_a_nxt = sq_a + pp_a;
        ctr_nxt  = ctr + 4'd1;
        if (ctr == 4'(C_W - 1)) state_nxt = DIFF;
      end
      DIFF: begin
        if ({2'b00, sq_a} > sq_c) begin
          b_nxt     = '0;
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          x_nxt     = sq_c - {2'b00, sq_a};
          res_nxt   = '0;
          m_nxt     = M_INIT;
          state_nxt = ROOT;
        end
      end
      ROOT: begin
        x_nxt   = step_x;
        res_nxt = step_res;
        m_nxt   = step_m;
        if (m == SQ_W'(1)) begin
          b_nxt     = step_res[C_W-1:0];
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      c_q   <= '0;
      a_q   <= '0;
      ctr   <= '0;
      sq_c  <= '0;
      sq_a  <= '0;
      x     <= '0;
      res   <= '0;
      m     <= '0;
      b_bo  <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      c_q   <= c_nxt;
      a_q   <= a_nxt;
      ctr   <= ctr_nxt;
      sq_c  <= sq_c_nxt;
      sq_a  <= sq_a_nxt;
      x     <= x_nxt;
      res   <= res_nxt;
      m     <= m_nxt;
      b_bo  <= b_nxt;
      err_o <= err_nxt;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_cathetus.sv
// Directed and random bench for cathetus with a cycle-level reference model.
module tb_cathetus;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [8:0] c_in = '0;
  logic [7:0] a_in = '0;
  logic [8:0] b;
  logic       err;
  logic       busy;

  int tests = 0;
  int fails = 0;

  cathetus dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .c_bi    (c_in),
    .a_bi    (a_in),
    .b_bo    (b),
    .err_o   (err),
    .busy_o  (busy)
  );

  always #5 clk = ~clk;

  // Reference leg length straight from the definition.
  function automatic int ref_leg(input int c, input int a);
    int d;
    int r;
    d = c * c - a * a;
    r = 0;
    if (d < 0) return 0;
    while ((r + 1) * (r + 1) <= d) r++;
    return r;
  endfunction

  // Abstract model: an operation is a countdown of 19 (or 10 on error) cycles, then results appear.
  logic m_busy = 1'b0;
  int   m_left = 0;
  int   m_b = 0;
  logic m_err = 1'b0;
  int   pend_b = 0;
  logic pend_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_left <= 0;
      m_b    <= 0;
      m_err  <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_b    <= pend_b;
        m_err  <= pend_err;
      end
      m_left <= m_left - 1;
    end else if (start) begin
      pend_err <= (int'(a_in) > int'(c_in));
      pend_b   <= ref_leg(int'(c_in), int'(a_in));
      m_left   <= (int'(a_in) > int'(c_in)) ? 10 : 19;
      m_busy   <= 1'b1;
    end
  end

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clk) begin
    tests++;
    if (busy !== m_busy) begin
      fails++;
      $display("FAIL cyc_busy t=%0t got %0b want %0b", $time, busy, m_busy);
    end
    tests++;
    if (int'(b) != m_b || $isunknown(b)) begin
      fails++;
      $display("FAIL cyc_b t=%0t got %0d want %0d", $time, b, m_b);
    end
    tests++;
    if (err !== m_err) begin
      fails++;
      $display("FAIL cyc_err t=%0t got %0b want %0b", $time, err, m_err);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Count busy cycles after the current sample point, bounded.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_op(input string name, input int c, input int a,
                        input int exp_b, input int exp_err, input int exp_cyc);
    int cnt;
    @(posedge clk);
    #1;
    start = 1'b1;
    c_in  = 9'(c);
    a_in  = 8'(a);
    @(posedge clk);
    #1;
    start = 1'b0;
    c_in  = '0;
    a_in  = '0;
    wait_idle(cnt);
    check({name, "_cycles"}, cnt, exp_cyc);
    check({name, "_b"}, int'(b), exp_b);
    check({name, "_err"}, int'(err), exp_err);
  endtask

  initial begin
    int cnt;
    int c;
    int a;
    int d;
    int bb;

    // Model pins: hand-computed legs.
    check("ref_5_3", ref_leg(5, 3), 4);
    check("ref_100_50", ref_leg(100, 50), 86);
    check("ref_511_0", ref_leg(511, 0), 511);
    check("ref_13_5", ref_leg(13, 5), 12);

    #12;
    check("reset_b", int'(b), 0);
    check("reset_err", int'(err), 0);
    check("reset_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op("c5a3", 5, 3, 4, 0, 19);
    run_op("c3a4", 3, 4, 0, 1, 10);
    run_op("c100a50", 100, 50, 86, 0, 19);
    run_op("c10a10", 10, 10, 0, 0, 19);
    run_op("c511a0", 511, 0, 511, 0, 19);
    run_op("c0a0", 0, 0, 0, 0, 19);
    run_op("c256a255", 256, 255, 22, 0, 19);
    run_op("c0a255", 0, 255, 0, 1, 10);

    // start held high with inputs changing during busy.
    @(posedge clk);
    #1;
    start = 1'b1;
    c_in  = 9'd13;
    a_in  = 8'd5;
    @(posedge clk);
    #1;
    c_in = 9'd100;
    a_in = 8'd60;
    wait_idle(cnt);
    check("hold_cycles", cnt, 19);
    check("hold_b", int'(b), 12);
    check("hold_idle_gap", int'(busy), 0);
    @(posedge clk);
    #1;
    check("hold_reaccept", int'(busy), 1);
    start = 1'b0;
    wait_idle(cnt);
    check("hold2_cycles", cnt, 19);
    check("hold2_b", int'(b), 80);

    // Reset mid-operation.
    @(posedge clk);
    #1;
    start = 1'b1;
    c_in  = 9'd200;
    a_in  = 8'd100;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_b", int'(b), 0);
    check("arst_err", int'(err), 0);
    check("arst_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("c13a5", 13, 5, 12, 0, 19);

    // Random sweep with a ≤ c and a bound check on each result.
    for (int i = 0; i < 60; i++) begin
      c = $urandom_range(0, 511);
      a = $urandom_range(0, (c > 255) ? 255 : c);
      run_op("sweep", c, a, ref_leg(c, a), 0, 19);
      d  = c * c - a * a;
      bb = int'(b);
      tests++;
      if (!(bb * bb <= d && d < (bb + 1) * (bb + 1))) begin
        fails++;
        $display("FAIL sweep_bound c=%0d a=%0d got %0d", c, a, bb);
      end
    end

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
